// File: rtl/cpu_gpio_periph_if.sv
// CPU-side GPIO bus: write data from the CPU, registered read data and change strobes back to it.
`default_nettype none

interface cpu_gpio_periph_if;
  logic [31:0] cpu_out;
  logic [31:0] cpu_in;
  logic        in_chg;
  logic        out_upd;

  modport master (
    output cpu_out,
    input  cpu_in,
    input  in_chg,
    input  out_upd
  );

  modport slave (
    input  cpu_out,
    output cpu_in,
    output in_chg,
    output out_upd
  );
endinterface

`default_nettype wire

// File: rtl/cpu_gpio_periph.sv
// Board-side GPIO endpoint: debounced switches feed the CPU read word,
// and the CPU write word drives an 8-digit multiplexed hex display.
`default_nettype none

module cpu_gpio_periph #(
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SCAN_DIV        = 50000,
  parameter bit LZ_BLANK        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SW-1:0]     sw,
  cpu_gpio_periph_if.slave      bus,
  output logic [7:0]            an,
  output logic [6:0]            seg
);

  localparam int                CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int                DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SCAN_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Input path state
  logic [NUM_SW-1:0] sync1_q, sync_q;
  logic [NUM_SW-1:0] cand_q, cand_d;
  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       cpu_in_q, cpu_in_d;
  logic              in_chg_q, in_chg_d;

  // Output path and display state
  logic [31:0]       prev_out_q;
  logic              out_upd_q, out_upd_d;
  logic [31:0]       frame_q, frame_d;
  logic [2:0]        idx_q, idx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [31:0]       upper_w;
  logic              blank_w;

  // Any difference between the synchronised value and the candidate restarts the hold count.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = cand_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    cpu_in_d  = 32'(stable_q);
    in_chg_d  = (cpu_in_d != cpu_in_q);
    out_upd_d = (bus.cpu_out != prev_out_q);
  end

  // Display outputs are computed from next-state idx/frame so an and seg always match idx_q.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    idx_d   = idx_q;
    frame_d = frame_q;
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        frame_d = prev_out_q;
      end
    end
    upper_w = frame_d >> {idx_d, 2'b00};
    blank_w = LZ_BLANK && (idx_d != 3'd0) && (upper_w == 32'd0);
    an_d    = ~(8'b1 << idx_d);
    seg_d   = blank_w ? 7'h7F : hex7(upper_w[3:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      cpu_in_q   <= '0;
      in_chg_q   <= 1'b0;
      prev_out_q <= '0;
      out_upd_q  <= 1'b0;
      frame_q    <= '0;
      idx_q      <= '0;
      div_q      <= '0;
      an_q       <= 8'hFE;
      seg_q      <= 7'b1000000;
    end else begin
      sync1_q    <= sw;
      sync_q     <= sync1_q;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      cpu_in_q   <= cpu_in_d;
      in_chg_q   <= in_chg_d;
      prev_out_q <= bus.cpu_out;
      out_upd_q  <= out_upd_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.cpu_in  = cpu_in_q;
  assign bus.in_chg  = in_chg_q;
  assign bus.out_upd = out_upd_q;
  assign an          = an_q;
  assign seg         = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_gpio_periph.sv
// Directed bench for cpu_gpio_periph: reset, debounce timing, bounce rejection, display scan and tearing.
`default_nettype none

module tb_cpu_gpio_periph;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [7:0] an;
  logic [6:0] seg;

  cpu_gpio_periph_if bus ();

  cpu_gpio_periph #(
    .NUM_SW(4),
    .DEBOUNCE_CYCLES(4),
    .SCAN_DIV(2),
    .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .bus(bus),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [55:0] segs;   // {digit7 .. digit0}, 7 bits each
  } disp_vec_t;

  disp_vec_t vt [6];
  int n_checks = 0;
  int n_pass   = 0;
  int n_inchg  = 0;

  always @(negedge clk) if (bus.in_chg === 1'b1) n_inchg++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to the first cycle of a fresh scan frame (an newly at FE).
  task automatic wait_frame();
    logic [7:0] pa;
    int t;
    t = 0;
    do begin
      pa = an;
      tick();
      t++;
    end while (!(an == 8'hFE && pa != 8'hFE) && t < 64);
    check("frame_found", 32'(t < 64), 32'd1);
  endtask

  // Positioned at the first cycle of digit `from`; checks an/seg through digit 7.
  task automatic check_digits(input int from, input logic [55:0] exp, input string tag);
    for (int i = from; i < 8; i++) begin
      check($sformatf("%s_an%0d", tag, i), {24'd0, an}, {24'd0, ~(8'b1 << i)});
      check($sformatf("%s_seg%0d", tag, i), {25'd0, seg}, {25'd0, exp[7*i +: 7]});
      if (i < 7) repeat (2) tick();
    end
  endtask

  initial begin
    int c0;
    logic bad;

    vt[0] = '{32'h1234_5678, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
    vt[1] = '{32'h9ABC_DEF0, {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}};
    vt[2] = '{32'h8000_0000, {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vt[3] = '{32'h0000_0010, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}};
    vt[4] = '{32'h0000_0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vt[5] = '{32'h00C0_FFEE, {7'h7F, 7'h7F, 7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06}};

    // Reset
    rst_n = 1'b0;
    sw = 4'h0;
    bus.cpu_out = 32'd0;
    repeat (2) tick();
    check("rst_cpu_in", bus.cpu_in, 32'd0);
    check("rst_an", {24'd0, an}, 32'hFE);
    check("rst_seg", {25'd0, seg}, 32'h40);
    check("rst_in_chg", {31'd0, bus.in_chg}, 32'd0);
    check("rst_out_upd", {31'd0, bus.out_upd}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("scan_hold", {24'd0, an}, 32'hFE);
    tick();
    check("scan_adv", {24'd0, an}, 32'hFD);

    // Clean switch edge: first visible on cpu_in at edge k+7
    @(negedge clk);
    sw = 4'hA;
    repeat (7) @(posedge clk);
    #1;
    check("clean_early", bus.cpu_in, 32'd0);
    check("clean_early_chg", {31'd0, bus.in_chg}, 32'd0);
    tick();
    check("clean_cpu_in", bus.cpu_in, 32'hA);
    check("clean_in_chg", {31'd0, bus.in_chg}, 32'd1);
    tick();
    check("clean_in_chg_drop", {31'd0, bus.in_chg}, 32'd0);

    @(negedge clk);
    sw = 4'h0;
    repeat (12) tick();
    check("sw_release", bus.cpu_in, 32'd0);

    // Bounce: A/0 every 2 clocks, then A held
    c0 = n_inchg;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.cpu_in != 32'd0) bad = 1'b1;
      sw = (i % 2 == 0) ? 4'hA : 4'h0;
      if (i < 4) begin
        @(negedge clk);
        if (bus.cpu_in != 32'd0) bad = 1'b1;
      end
    end
    for (int j = 0; j < 7; j++) begin
      @(posedge clk);
      #1;
      if (bus.cpu_in != 32'd0) bad = 1'b1;
    end
    check("bounce_quiet", {31'd0, bad}, 32'd0);
    tick();
    check("bounce_settle", bus.cpu_in, 32'hA);
    repeat (5) tick();
    check("bounce_one_chg", 32'(n_inchg - c0), 32'd1);

    // Display vectors
    for (int e = 0; e < 6; e++) begin
      bus.cpu_out = vt[e].data;
      tick();
      check($sformatf("upd_pulse%0d", e), {31'd0, bus.out_upd}, 32'd1);
      tick();
      check($sformatf("upd_drop%0d", e), {31'd0, bus.out_upd}, 32'd0);
      wait_frame();
      check_digits(0, vt[e].segs, $sformatf("disp%0d", e));
    end

    // Mid-frame write: current frame must finish with the old value
    wait_frame();
    repeat (6) tick();
    check("mid_at_d3", {24'd0, an}, 32'hF7);
    bus.cpu_out = 32'h1234_5678;
    check("mid_d3_now", {25'd0, seg}, 32'h0E);
    tick();
    check("mid_upd", {31'd0, bus.out_upd}, 32'd1);
    check("mid_d3_hold", {25'd0, seg}, 32'h0E);
    tick();
    check("mid_upd_drop", {31'd0, bus.out_upd}, 32'd0);
    check_digits(4, vt[5].segs, "mid_old");
    repeat (2) tick();
    check_digits(0, vt[0].segs, "mid_new");

    // Reset in the middle of a debounce
    bus.cpu_out = 32'd0;
    repeat (3) tick();
    c0 = n_inchg;
    @(negedge clk);
    sw = 4'h5;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sw = 4'h0;
    repeat (2) tick();
    check("rst2_cpu_in", bus.cpu_in, 32'd0);
    check("rst2_an", {24'd0, an}, 32'hFE);
    check("rst2_seg", {25'd0, seg}, 32'h40);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (bus.out_upd !== 1'b0) bad = 1'b1;
    end
    check("rst2_no_upd", {31'd0, bad}, 32'd0);
    check("rst2_no_chg", 32'(n_inchg - c0), 32'd0);
    check("rst2_cpu_in_hold", bus.cpu_in, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
